// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// majority vote and parameter legality checks.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic bit data_bits_ok(input int unsigned n);
        return (n >= 5) && (n <= 9);
    endfunction

    function automatic bit stop_bits_ok(input int unsigned n);
        return (n == 1) || (n == 2);
    endfunction

    function automatic bit oversample_ok(input int unsigned n);
        return (n >= 8) && (n <= 32) && ((n % 2) == 0);
    endfunction

    function automatic bit sync_stages_ok(input int unsigned n);
        return (n >= 2) && (n <= 4);
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Parity generator: returns the parity bit a sender would append to data
// (even parity, or odd parity when odd is set).
module uart_parity #(
    parameter int unsigned DataWidth = 8
) (
    input  logic [DataWidth-1:0] data,
    input  logic                 odd,
    output logic                 parity
);

    assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_rx_sampler.sv
// Line front end: input synchroniser, oversample counter and 3-sample
// majority vote centred on the middle of each bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OversampleRate = 16,
    parameter int unsigned SyncStages     = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic uart_clk_en_i,
    input  logic uart_rxd_i,
    input  logic idle,
    output logic rxd_s,
    output logic mid_o,
    output logic wrap_o,
    output logic vote_o
);

    localparam int unsigned ScW  = $clog2(OversampleRate);
    localparam int unsigned Half = OversampleRate / 2;

    localparam logic [ScW-1:0] ScFirst  = ScW'(Half - 1);
    localparam logic [ScW-1:0] ScCentre = ScW'(Half);
    localparam logic [ScW-1:0] ScLast   = ScW'(Half + 1);
    localparam logic [ScW-1:0] ScWrap   = ScW'(OversampleRate - 1);

    logic [SyncStages-1:0] sync;
    logic [ScW-1:0]        sc;
    logic                  s_first;
    logic                  s_centre;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync <= '1;
        end else begin
            sync <= {sync[SyncStages-2:0], uart_rxd_i};
        end
    end

    assign rxd_s = sync[SyncStages-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sc       <= '0;
            s_first  <= 1'b1;
            s_centre <= 1'b1;
        end else if (uart_clk_en_i) begin
            if (idle || (sc == ScWrap)) begin
                sc <= '0;
            end else begin
                sc <= sc + 1'b1;
            end
            if (sc == ScFirst) begin
                s_first <= rxd_s;
            end
            if (sc == ScCentre) begin
                s_centre <= rxd_s;
            end
        end
    end

    // The third sample is the live line value on the resolving tick.
    assign mid_o  = uart_clk_en_i && (sc == ScLast);
    assign wrap_o = uart_clk_en_i && (sc == ScWrap);
    assign vote_o = maj3(s_first, s_centre, rxd_s);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: configurable data/parity/stop format with false-start
// rejection and break detection, timed by the shared oversample tick.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int unsigned DataBits       = 8,
    parameter string       ParityBit      = "none",
    parameter int unsigned StopBits       = 1,
    parameter int unsigned OversampleRate = 16,
    parameter int unsigned SyncStages     = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                uart_clk_en_i,
    input  logic                uart_rxd_i,
    output logic [DataBits-1:0] data_o,
    output logic                data_valid_o,
    output logic                frame_error_o,
    output logic                parity_error_o,
    output logic                break_o,
    output logic                busy_o
);

    localparam bit          ParityEn  = (ParityBit != "none");
    localparam bit          ParityOdd = (ParityBit == "odd");
    localparam int unsigned CntW      = $clog2(DataBits + 1);

    localparam logic [CntW-1:0] LastBit  = CntW'(DataBits);
    localparam logic            LastStop = 1'(StopBits - 1);

    if (!data_bits_ok(DataBits)) begin : g_bad_data_bits
        $error("uart_rx_ext: DataBits must be in 5..9");
    end
    if (!stop_bits_ok(StopBits)) begin : g_bad_stop_bits
        $error("uart_rx_ext: StopBits must be 1 or 2");
    end
    if (!oversample_ok(OversampleRate)) begin : g_bad_oversample
        $error("uart_rx_ext: OversampleRate must be even and in 8..32");
    end
    if (!sync_stages_ok(SyncStages)) begin : g_bad_sync
        $error("uart_rx_ext: SyncStages must be in 2..4");
    end
    if ((ParityBit != "none") && (ParityBit != "even") && (ParityBit != "odd")) begin : g_bad_par
        $error("uart_rx_ext: ParityBit must be none, even or odd");
    end

    rx_state_t           state;
    logic [CntW-1:0]     bit_cnt;
    logic [DataBits-1:0] shreg;
    logic                parity_err;
    logic                par_sample;
    logic                stop_bad;
    logic                stop_cnt;

    logic rxd_s;
    logic mid;
    logic wrap;
    logic vote;
    logic exp_parity;
    logic stop_bad_now;
    logic is_break;

    uart_rx_sampler #(
        .OversampleRate(OversampleRate),
        .SyncStages    (SyncStages)
    ) u_sampler (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .uart_clk_en_i(uart_clk_en_i),
        .uart_rxd_i   (uart_rxd_i),
        .idle         (state == StIdle),
        .rxd_s        (rxd_s),
        .mid_o        (mid),
        .wrap_o       (wrap),
        .vote_o       (vote)
    );

    uart_parity #(
        .DataWidth(DataBits)
    ) u_parity (
        .data  (shreg),
        .odd   (ParityOdd),
        .parity(exp_parity)
    );

    assign stop_bad_now = stop_bad | ~vote;
    // A break is an all-low frame: data, parity bit (if any) and stop bit.
    assign is_break     = (shreg == '0) && (!ParityEn || !par_sample) && stop_bad_now;
    assign busy_o       = (state != StIdle);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= StIdle;
            bit_cnt        <= '0;
            shreg          <= '0;
            parity_err     <= 1'b0;
            par_sample     <= 1'b0;
            stop_bad       <= 1'b0;
            stop_cnt       <= 1'b0;
            data_o         <= '0;
            data_valid_o   <= 1'b0;
            frame_error_o  <= 1'b0;
            parity_error_o <= 1'b0;
            break_o        <= 1'b0;
        end else begin
            data_valid_o   <= 1'b0;
            frame_error_o  <= 1'b0;
            parity_error_o <= 1'b0;
            break_o        <= 1'b0;
            if (uart_clk_en_i) begin
                unique case (state)
                    StIdle: begin
                        if (!rxd_s) begin
                            state      <= StStart;
                            bit_cnt    <= '0;
                            parity_err <= 1'b0;
                            par_sample <= 1'b0;
                            stop_bad   <= 1'b0;
                            stop_cnt   <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (mid && vote) begin
                            state <= StIdle;
                        end else if (wrap) begin
                            state <= StData;
                        end
                    end
                    StData: begin
                        if (mid) begin
                            shreg   <= {vote, shreg[DataBits-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (wrap && (bit_cnt == LastBit)) begin
                            state <= ParityEn ? StParity : StStop;
                        end
                    end
                    StParity: begin
                        if (mid) begin
                            par_sample <= vote;
                            parity_err <= vote ^ exp_parity;
                        end
                        if (wrap) begin
                            state <= StStop;
                        end
                    end
                    StStop: begin
                        if (mid) begin
                            stop_bad <= stop_bad_now;
                            // Leave at mid of the last stop bit for half a bit of resync margin.
                            if (stop_cnt == LastStop) begin
                                if (is_break) begin
                                    break_o       <= 1'b1;
                                    frame_error_o <= 1'b1;
                                    state         <= StBrkWait;
                                end else begin
                                    frame_error_o  <= stop_bad_now;
                                    parity_error_o <= parity_err;
                                    data_valid_o   <= ~stop_bad_now & ~parity_err;
                                    if (!stop_bad_now && !parity_err) begin
                                        data_o <= shreg;
                                    end
                                    state <= StIdle;
                                end
                            end
                        end else if (wrap) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    StBrkWait: begin
                        if (rxd_s) begin
                            state <= StIdle;
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 and a 7E2 receiver driven by a tick-level line
// model, with expected frame outcomes queued and checked by a monitor.
module tb_uart_rx_ext;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic rxd0  = 1'b1;
    logic rxd1  = 1'b1;

    logic [7:0] data0;
    logic [6:0] data1;
    logic valid0, ferr0, perr0, brk0, busy0;
    logic valid1, ferr1, perr1, brk1, busy1;

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic       brk;
        logic [8:0] data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [8:0] last0 = '0;
    logic [8:0] last1 = '0;
    int         checks = 0;
    int         fails = 0;
    int         busy_ticks0 = 0;
    int unsigned tick_div = 0;

    always #5 clk = ~clk;

    // One oversample tick every fourth clock.
    always @(posedge clk) begin
        if (tick_div == 3) begin
            tick_div <= 0;
            tick     <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            tick     <= 1'b0;
        end
    end

    uart_rx_ext u_dut0 (
        .clk_i         (clk),
        .reset_i       (reset),
        .uart_clk_en_i (tick),
        .uart_rxd_i    (rxd0),
        .data_o        (data0),
        .data_valid_o  (valid0),
        .frame_error_o (ferr0),
        .parity_error_o(perr0),
        .break_o       (brk0),
        .busy_o        (busy0)
    );

    uart_rx_ext #(
        .DataBits (7),
        .ParityBit("even"),
        .StopBits (2)
    ) u_dut1 (
        .clk_i         (clk),
        .reset_i       (reset),
        .uart_clk_en_i (tick),
        .uart_rxd_i    (rxd1),
        .data_o        (data1),
        .data_valid_o  (valid1),
        .frame_error_o (ferr1),
        .parity_error_o(perr1),
        .break_o       (brk1),
        .busy_o        (busy1)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick);
            #1;
        end
    endtask

    task automatic drive(input bit which, input logic lvl, input int n);
        if (which) rxd1 = lvl;
        else rxd0 = lvl;
        wait_ticks(n);
    endtask

    // Frame outcome from the line-level rules: what was sent decides the pulses.
    task automatic push_exp(input bit which, input logic [8:0] d, input bit flip,
                            input bit stop_low);
        exp_t       e;
        logic [8:0] dm;
        logic       pbit;
        dm    = which ? {2'b00, d[6:0]} : {1'b0, d[7:0]};
        pbit  = (^dm) ^ flip;
        e.brk = stop_low && (dm == 9'd0) && (!which || !pbit);
        e.fe  = stop_low;
        e.pe  = which && flip && !e.brk;
        e.v   = !stop_low && !(which && flip);
        if (which) begin
            if (e.v) last1 = dm;
            e.data = last1;
            q1.push_back(e);
        end else begin
            if (e.v) last0 = dm;
            e.data = last0;
            q0.push_back(e);
        end
    endtask

    task automatic send_frame(input bit which, input logic [8:0] d, input bit flip,
                              input bit stop_low);
        int nbits;
        int nstop;
        nbits = which ? 7 : 8;
        nstop = which ? 2 : 1;
        push_exp(which, d, flip, stop_low);
        drive(which, 1'b0, 16);
        for (int i = 0; i < nbits; i++) drive(which, d[i], 16);
        if (which) drive(which, (^d[6:0]) ^ flip, 16);
        for (int s = 0; s < nstop; s++) drive(which, !stop_low, 16);
        drive(which, 1'b1, 24);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid0 | ferr0 | perr0 | brk0) begin
                if (q0.size() == 0) begin
                    cmp("dut0_spurious_pulse", {28'd0, brk0, perr0, ferr0, valid0}, 32'd0);
                end else begin
                    e = q0.pop_front();
                    cmp("dut0_frame", {19'd0, brk0, perr0, ferr0, valid0, 1'b0, data0},
                        {19'd0, e.brk, e.pe, e.fe, e.v, e.data});
                end
            end
            if (valid1 | ferr1 | perr1 | brk1) begin
                if (q1.size() == 0) begin
                    cmp("dut1_spurious_pulse", {28'd0, brk1, perr1, ferr1, valid1}, 32'd0);
                end else begin
                    e = q1.pop_front();
                    cmp("dut1_frame", {19'd0, brk1, perr1, ferr1, valid1, 2'b00, data1},
                        {19'd0, e.brk, e.pe, e.fe, e.v, e.data});
                end
            end
        end
    endtask

    task automatic busy_counter();
        forever begin
            @(posedge clk);
            if (tick && busy0) busy_ticks0++;
        end
    endtask

    initial begin
        int          b0;
        logic [8:0]  d;
        fork
            monitor();
            busy_counter();
        join_none

        repeat (4) @(posedge clk);
        #1;
        cmp("reset_dut0_outputs", {data0, valid0, ferr0, perr0, brk0, busy0}, 32'd0);
        cmp("reset_dut1_outputs", {data1, valid1, ferr1, perr1, brk1, busy1}, 32'd0);
        reset = 1'b0;
        wait_ticks(8);

        send_frame(1'b0, 9'h0A5, 1'b0, 1'b0);
        cmp("busy_low_after_a5", busy0, 1'b0);

        send_frame(1'b1, 9'h035, 1'b0, 1'b0);
        send_frame(1'b1, 9'h035, 1'b1, 1'b0);
        cmp("busy_low_after_7e2", busy1, 1'b0);

        // Short low glitch on an idle line must be rejected as a false start.
        b0 = busy_ticks0;
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 30);
        cmp("false_start_busy_ticks_ok",
            ((busy_ticks0 - b0) >= 8) && ((busy_ticks0 - b0) <= 11), 1'b1);
        cmp("false_start_busy_low", busy0, 1'b0);

        // Single-tick high glitch at the centre sample of data bit 3.
        push_exp(1'b0, 9'h000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                drive(1'b0, 1'b0, 9);
                drive(1'b0, 1'b1, 1);
                drive(1'b0, 1'b0, 6);
            end else begin
                drive(1'b0, 1'b0, 16);
            end
        end
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b1, 24);

        send_frame(1'b0, 9'h05A, 1'b0, 1'b1);

        // Line held low for three frame times: one break, then recovery.
        push_exp(1'b0, 9'h000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 480);
        drive(1'b0, 1'b1, 24);
        cmp("busy_low_after_break", busy0, 1'b0);
        send_frame(1'b0, 9'h011, 1'b0, 1'b0);

        // Reset during data bit 4 of 0xF5; the rest of that frame is high.
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 5);
        cmp("busy_before_reset", busy0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        last0 = '0;
        last1 = '0;
        cmp("busy_after_reset", busy0, 1'b0);
        cmp("data_after_reset", data0, 8'h00);
        drive(1'b0, 1'b1, 11 + 3 * 16 + 16 + 24);
        send_frame(1'b0, 9'h0C3, 1'b0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
            send_frame(1'b0, d, 1'b0, $urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
            send_frame(1'b1, d, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        wait_ticks(40);
        cmp("dut0_queue_drained", q0.size(), 32'd0);
        cmp("dut1_queue_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
